rr_arbiter_4: RTL and testbench
===============================

Name: rr_arbiter_4

Overview:
- Four-requester round-robin arbiter that shares one resource slot between requesters 0..3.
- Internally holds a 2-bit grant index. A 2-to-4 decode of that index drives the one-hot grant bus.
- Sits in front of any shared datapath unit. Requesters raise req, own the resource while gnt is high, and release it by dropping req.

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles one owner keeps the grant while others wait. Legal range 2..255. Used only when ARB_TIMEOUT_EN is defined.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  4  request lines, bit i = requester i; level-held by requester
- gnt  output  4  one-hot grant (registered); all zeros when idle
- gnt_id  output  2  index of current owner; valid only when gnt_valid=1
- gnt_valid  output  1  high when exactly one gnt bit is high
- timeout  output  1  one-cycle pulse on a preemption (ARB_TIMEOUT_EN only; tied 0 otherwise)

Behaviour:
- Single clock domain. rst_n asynchronous assert, synchronous deassert is the system's job.
- Reset values: state=IDLE, ptr=0, gnt=4'b0000, gnt_id=0, gnt_valid=0, timeout=0, hold_cnt=0.
- Grant encoding: gnt = decode2to4(gnt_id) when gnt_valid, else 0. Never more than one bit high.
- Selection function sel(ptr, mask): the first requester set in mask, searching ptr, ptr+1, ... modulo 4. The search wraps 3->0.
- State IDLE:
  - If req!=0, go to GRANT next edge with gnt_id=sel(ptr, req).
  - Latency is 1 cycle from req seen to gnt high.
- State GRANT, release (req[gnt_id]=0):
  - ptr <= gnt_id+1 (mod 4).
  - If other requests are pending, grant sel(gnt_id+1, req) on the next edge. This is a back-to-back grant with no idle gap.
  - Otherwise go to IDLE and gnt=0 next cycle.
- State GRANT, hold (req[gnt_id]=1): the grant is unchanged. hold_cnt increments and saturates at MAX_HOLD-1.
- hold_cnt resets to 0 on every new grant.
- Simultaneous events:
  - A requester that drops and re-raises req in the same cycle it is granted is still treated as holding.
  - A requester that releases and asserts again later waits its round-robin turn.
- A request that disappears before it is granted is simply not granted. There is no latching of requests.
- Reset mid-grant: gnt drops asynchronously to 0 and ptr returns to 0.
- Fairness: with all four requesting and each releasing after one cycle, grants rotate 0,1,2,3,0,...

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- When defined:
  - In GRANT with hold_cnt==MAX_HOLD-1, the owner still requesting, and (req & ~gnt)!=0, the arbiter preempts.
  - On preemption, the next edge grants sel(gnt_id+1, req & ~gnt), sets ptr=gnt_id+1, and pulses timeout=1 for one cycle.
  - If no other requester is waiting, there is no preemption. The owner keeps the grant indefinitely and hold_cnt stays saturated.
- When undefined:
  - No hold counter; the owner keeps the grant until it drops req.
  - timeout is tied 0 and MAX_HOLD is ignored.

Test Plan:
- Reset: hold rst_n=0 with req=4'b1111 -> gnt=0, gnt_valid=0, gnt_id=0. Release reset -> one cycle later gnt=4'b0001, gnt_id=0.
- Rotation: req=4'b1111, each owner drops req for one cycle after being granted -> gnt sequence 0001,0010,0100,1000,0001 with no idle cycle between grants.
- Wrap and skip: ptr=3, req=4'b0010 -> gnt=4'b0010, gnt_id=1. On release with req=0 -> gnt=0 the next cycle, state IDLE, ptr=2.
- Hold: req=4'b0100 held for 20 cycles, no other requests -> gnt=4'b0100 steady for all cycles, timeout never pulses (both macro settings).
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD=4): req[0] held and req[2] raised on cycle 1 of the grant -> after 4 grant cycles gnt switches 0001->0100 and timeout=1 for exactly one cycle. Without the macro, gnt stays 0001 until req[0] drops.
- Reset mid-grant: assert rst_n=0 while gnt=4'b1000 -> gnt=0 immediately, without waiting for a clock edge. After release with req=4'b1001 -> grant goes to requester 0, since ptr was reset to 0.

Source files
------------

// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle between the requesters (master) and rr_arbiter_4 (slave).
interface rr_arbiter_4_if;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    modport master (output req, input gnt, gnt_id, gnt_valid, timeout);
    modport slave  (input req, output gnt, gnt_id, gnt_valid, timeout);
endinterface

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with registered one-hot grant.
// Optional owner preemption after MAX_HOLD cycles is enabled by macro ARB_TIMEOUT_EN.
module rr_arbiter_4 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input logic           clk,
    input logic           rst_n,
    rr_arbiter_4_if.slave arb
);
    typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;

    state_t     r_state, w_state_nxt;
    logic [1:0] r_ptr, w_ptr_nxt;
    logic [1:0] r_gnt_id, w_gnt_id_nxt;
    logic [3:0] r_gnt, w_gnt_nxt;
    logic       r_gnt_valid;
    logic [1:0] w_id_inc;
    logic       w_owner_req;

    if ((MAX_HOLD < 2) || (MAX_HOLD > 255)) begin : g_bad_max_hold
        $error("rr_arbiter_4: MAX_HOLD must be within 2..255");
    end

    // First requester set in mask, searching from ptr upward with wrap 3->0.
    function automatic logic [1:0] sel(input logic [1:0] ptr, input logic [3:0] mask);
        logic [1:0] idx;
        sel = ptr;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (mask[idx]) begin
                sel = idx;
            end else begin
                sel = sel;
            end
        end
    endfunction

    function automatic logic [3:0] dec2to4(input logic [1:0] id);
        dec2to4 = 4'b0001 << id;
    endfunction

    assign w_id_inc    = r_gnt_id + 2'd1;
    assign w_owner_req = arb.req[r_gnt_id];

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 32'd1);

    logic [7:0] r_hold_cnt, w_hold_cnt_nxt;
    logic       r_timeout, w_timeout_nxt;
    logic       w_preempt;

    assign w_preempt = (r_hold_cnt == HOLD_LAST) && ((arb.req & ~r_gnt) != 4'b0000);
`endif

    // Next-state, next-owner and pointer update
    always_comb begin
        w_state_nxt  = r_state;
        w_ptr_nxt    = r_ptr;
        w_gnt_id_nxt = r_gnt_id;
        w_gnt_nxt    = 4'b0000;
`ifdef ARB_TIMEOUT_EN
        w_hold_cnt_nxt = r_hold_cnt;
        w_timeout_nxt  = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (arb.req != 4'b0000) begin
                    w_state_nxt  = ST_GRANT;
                    w_gnt_id_nxt = sel(r_ptr, arb.req);
`ifdef ARB_TIMEOUT_EN
                    w_hold_cnt_nxt = 8'd0;
`endif
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (!w_owner_req) begin
                    w_ptr_nxt = w_id_inc;
`ifdef ARB_TIMEOUT_EN
                    w_hold_cnt_nxt = 8'd0;
`endif
                    if (arb.req != 4'b0000) begin
                        w_state_nxt  = ST_GRANT;
                        w_gnt_id_nxt = sel(w_id_inc, arb.req);
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
`ifdef ARB_TIMEOUT_EN
                end else if (w_preempt) begin
                    w_gnt_id_nxt   = sel(w_id_inc, arb.req & ~r_gnt);
                    w_ptr_nxt      = w_id_inc;
                    w_timeout_nxt  = 1'b1;
                    w_hold_cnt_nxt = 8'd0;
                end else if (r_hold_cnt != HOLD_LAST) begin
                    w_hold_cnt_nxt = r_hold_cnt + 8'd1;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt;
`endif
                end else begin
                    w_gnt_id_nxt = r_gnt_id;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_state_nxt == ST_GRANT) begin
            w_gnt_nxt = dec2to4(w_gnt_id_nxt);
        end else begin
            w_gnt_nxt = 4'b0000;
        end
    end

    // State, round-robin pointer and registered grant outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= 2'd0;
            r_gnt_id    <= 2'd0;
            r_gnt       <= 4'b0000;
            r_gnt_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_gnt_id    <= w_gnt_id_nxt;
            r_gnt       <= w_gnt_nxt;
            r_gnt_valid <= (w_state_nxt == ST_GRANT);
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Hold counter and one-cycle preemption pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_cnt <= 8'd0;
            r_timeout  <= 1'b0;
        end else begin
            r_hold_cnt <= w_hold_cnt_nxt;
            r_timeout  <= w_timeout_nxt;
        end
    end

    assign arb.timeout = r_timeout;
`else
    assign arb.timeout = 1'b0;
`endif

    assign arb.gnt       = r_gnt;
    assign arb.gnt_id    = r_gnt_id;
    assign arb.gnt_valid = r_gnt_valid;
endmodule

// File: tb/tb_rr_arbiter_4.sv
// Self-checking bench for rr_arbiter_4: directed literal scenarios plus randomized
// requests compared every cycle against a behavioural round-robin model.
module tb_rr_arbiter_4;
    localparam int MAXH = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    rr_arbiter_4_if u_if ();

    rr_arbiter_4 #(.MAX_HOLD(MAXH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .arb   (u_if.slave)
    );

    always #5 clk = ~clk;

    // Model state: owner index (-1 when idle), round-robin pointer, hold age, timeout pulse.
    int   m_owner = -1;
    int   m_ptr   = 0;
    int   m_hold  = 0;
    logic m_to    = 1'b0;

    function automatic int sel(input int p, input logic [3:0] m);
        for (int k = 0; k < 4; k++) begin
            if (m[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural reference: who owns the slot after each edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner <= -1;
            m_ptr   <= 0;
            m_hold  <= 0;
            m_to    <= 1'b0;
        end else begin
            m_to <= 1'b0;
            if (m_owner < 0) begin
                m_owner <= sel(m_ptr, u_if.req);
                m_hold  <= 0;
            end else if (!u_if.req[m_owner]) begin
                m_ptr   <= (m_owner + 1) % 4;
                m_owner <= sel((m_owner + 1) % 4, u_if.req);
                m_hold  <= 0;
            end else begin
`ifdef ARB_TIMEOUT_EN
                if (m_hold == MAXH - 1 && (u_if.req & ~(4'b0001 << m_owner)) != 4'b0000) begin
                    m_owner <= sel((m_owner + 1) % 4, u_if.req & ~(4'b0001 << m_owner));
                    m_ptr   <= (m_owner + 1) % 4;
                    m_hold  <= 0;
                    m_to    <= 1'b1;
                end else if (m_hold < MAXH - 1) begin
                    m_hold <= m_hold + 1;
                end
`endif
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("gnt", 32'(u_if.gnt), (m_owner < 0) ? 32'h0 : 32'(4'b0001 << m_owner));
            check("gnt_valid", 32'(u_if.gnt_valid), 32'(m_owner >= 0));
            check("timeout", 32'(u_if.timeout), 32'(m_to));
            if (m_owner >= 0) check("gnt_id", 32'(u_if.gnt_id), 32'(m_owner));
        end
    end

    task automatic tick(input logic [3:0] r);
        u_if.req = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] rot_exp [0:3];
        logic [3:0] rq;
        logic [3:0] rr;

        rot_exp[0] = 4'b0010;
        rot_exp[1] = 4'b0100;
        rot_exp[2] = 4'b1000;
        rot_exp[3] = 4'b0001;

        rst_n    = 1'b0;
        u_if.req = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt", 32'(u_if.gnt), 32'h0);
        check("rst_valid", 32'(u_if.gnt_valid), 32'h0);
        check("rst_id", 32'(u_if.gnt_id), 32'h0);
        check("rst_timeout", 32'(u_if.timeout), 32'h0);
        rst_n = 1'b1;
        tick(4'b1111);
        check("first_gnt", 32'(u_if.gnt), 32'h1);
        check("first_id", 32'(u_if.gnt_id), 32'h0);

        // Rotation: each owner drops its request for the one cycle it holds the grant.
        for (int i = 0; i < 4; i++) begin
            rq = 4'b0001 << i;
            tick(4'b1111 & ~rq);
            check("rot_gnt", 32'(u_if.gnt), 32'(rot_exp[i]));
            check("rot_valid", 32'(u_if.gnt_valid), 32'h1);
        end

        // Wrap and skip from ptr=3.
        tick(4'b0000);
        tick(4'b0100);
        tick(4'b0000);
        check("idle_gnt", 32'(u_if.gnt), 32'h0);
        tick(4'b0010);
        check("wrap_gnt", 32'(u_if.gnt), 32'h2);
        check("wrap_id", 32'(u_if.gnt_id), 32'h1);
        tick(4'b0000);
        check("wrap_release", 32'(u_if.gnt), 32'h0);
        check("wrap_rel_valid", 32'(u_if.gnt_valid), 32'h0);
        tick(4'b1111);
        check("ptr2_gnt", 32'(u_if.gnt), 32'h4);

        // Long hold with no competitors.
        tick(4'b0000);
        tick(4'b0100);
        for (int i = 0; i < 20; i++) begin
            tick(4'b0100);
            check("hold_gnt", 32'(u_if.gnt), 32'h4);
            check("hold_timeout", 32'(u_if.timeout), 32'h0);
        end

        // Owner 0 holds; requester 2 arrives on grant cycle 1.
        tick(4'b0000);
        tick(4'b0001);
        check("to_start", 32'(u_if.gnt), 32'h1);
        for (int i = 0; i < 3; i++) begin
            tick((i == 0) ? 4'b0001 : 4'b0101);
            check("to_wait_gnt", 32'(u_if.gnt), 32'h1);
            check("to_wait_pulse", 32'(u_if.timeout), 32'h0);
        end
`ifdef ARB_TIMEOUT_EN
        tick(4'b0101);
        check("to_switch", 32'(u_if.gnt), 32'h4);
        check("to_pulse", 32'(u_if.timeout), 32'h1);
        tick(4'b0101);
        check("to_after", 32'(u_if.gnt), 32'h4);
        check("to_pulse_end", 32'(u_if.timeout), 32'h0);
`else
        tick(4'b0101);
        check("nto_keep", 32'(u_if.gnt), 32'h1);
        check("nto_pulse", 32'(u_if.timeout), 32'h0);
        tick(4'b0100);
        check("nto_switch", 32'(u_if.gnt), 32'h4);
        check("nto_pulse2", 32'(u_if.timeout), 32'h0);
`endif

        // Reset mid-grant: grant must fall without a clock edge; ptr returns to 0.
        tick(4'b0000);
        tick(4'b1000);
        check("mid_gnt", 32'(u_if.gnt), 32'h8);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_gnt", 32'(u_if.gnt), 32'h0);
        check("mid_rst_valid", 32'(u_if.gnt_valid), 32'h0);
        tick(4'b1001);
        rst_n = 1'b1;
        tick(4'b1001);
        check("post_rst_gnt", 32'(u_if.gnt), 32'h1);
        check("post_rst_id", 32'(u_if.gnt_id), 32'h0);

        // Randomized request patterns with level-held, occasionally toggling lines.
        rr = 4'b0000;
        for (int c = 0; c < 600; c++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 3) == 0) rr[b] = ~rr[b];
            end
            if (c == 300) begin
                #2;
                rst_n = 1'b0;
                #1;
                check("rand_rst_gnt", 32'(u_if.gnt), 32'h0);
                tick(rr);
                tick(rr);
                rst_n = 1'b1;
            end
            tick(rr);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
